// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming signed max-pooling over non-overlapping POOLxPOOL
// windows of a raster-order frame. A single row of per-window-column partial
// maxima replaces full-frame storage; a single output register with
// valid/ready back-pressure feeds the next stage.
// Optional feature: define MAXPOOL_RELU_EN to clamp each result at zero (fused ReLU).
module maxpool_stream #(
    parameter int DATA_BITS = 8,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int POOL      = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic signed [DATA_BITS-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [DATA_BITS-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        frame_done
);

    localparam int WIN_COLS = IMG_W / POOL;
    localparam int WIN_ROWS = IMG_H / POOL;
    localparam int P_W      = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int WC_W     = (WIN_COLS > 1) ? $clog2(WIN_COLS) : 1;
    localparam int WR_W     = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;

    localparam logic [P_W-1:0]  P_LAST  = P_W'(POOL - 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WIN_COLS - 1);
    localparam logic [WR_W-1:0] WR_LAST = WR_W'(WIN_ROWS - 1);

    // Position inside the frame, split into in-window offset and window index:
    // col = wc*POOL + px, row = wr*POOL + py.
    logic [P_W-1:0]  px;
    logic [P_W-1:0]  py;
    logic [WC_W-1:0] wc;
    logic [WR_W-1:0] wr;

    logic signed [DATA_BITS-1:0] acc;
    logic signed [DATA_BITS-1:0] lbuf [WIN_COLS];
    logic                        out_last;

    logic                        in_fire;
    logic                        out_fire;
    logic                        row_end;
    logic                        win_end;
    logic signed [DATA_BITS-1:0] h_max;
    logic signed [DATA_BITS-1:0] lb_rd;
    logic signed [DATA_BITS-1:0] win_max;
    logic signed [DATA_BITS-1:0] result;

    // Handshakes: the output register frees up in the same cycle it drains.
    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Window bookkeeping and the two max stages; ties keep the older operand.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        h_max   = acc;
        lb_rd   = lbuf[wc];
        win_max = lb_rd;
        result  = '0;
        row_end = (px == P_LAST) && (wc == WC_LAST);
        win_end = (px == P_LAST) && (py == P_LAST);

        if (in_data > acc) begin
            h_max = in_data;
        end
        if (h_max > lb_rd) begin
            win_max = h_max;
        end
`ifdef MAXPOOL_RELU_EN
        result = (win_max < 0) ? '0 : win_max;
`else
        result = win_max;
`endif
    end

    // Position counters, horizontal accumulator, output register and frame pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with <= only, so every read here sees the pre-edge value.
        if (!reset_n) begin
            px         <= '0;
            py         <= '0;
            wc         <= '0;
            wr         <= '0;
            acc        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_fire && out_last;

            if (out_fire) begin
                out_valid <= 1'b0;
            end

            if (in_fire) begin
                acc <= (px == '0) ? in_data : h_max;

                if (px == P_LAST) begin
                    px <= '0;
                    if (wc == WC_LAST) begin
                        wc <= '0;
                        if (py == P_LAST) begin
                            py <= '0;
                            wr <= (wr == WR_LAST) ? '0 : wr + 1'b1;
                        end else begin
                            py <= py + 1'b1;
                        end
                    end else begin
                        wc <= wc + 1'b1;
                    end
                end else begin
                    px <= px + 1'b1;
                end

                // A completing window reloads the register even while it drains.
                if (win_end) begin
                    out_data  <= result;
                    out_valid <= 1'b1;
                    out_last  <= row_end && (wr == WR_LAST);
                end
            end
        end
    end

    // Line buffer of running column maxima for the current window row.
    always_ff @(posedge clk) begin
        // NOTE: lbuf is deliberately left out of reset; each entry is written at py==0 before any read, and this keeps it mappable to RAM.
        if (in_fire && (px == P_LAST) && (py != P_LAST)) begin
            lbuf[wc] <= (py == '0) ? h_max : win_max;
        end
    end

endmodule
